encryption_core: RTL and testbench
==================================

// Module: encryption_core
// PURPOSE
//  Byte-serial Caesar (rotation) cipher for ASCII text. Each enabled cycle it takes one
//  character, rotates letters A-Z / a-z forward (encrypt) or backward (decrypt) by a
//  programmable shift with alphabet wrap-around, and registers the result with a valid
//  strobe. It sits between a byte source and the link or storage consumer.
// PARAMETERS
//  N  8  data width in bits; letter detection and rotation use ASCII codes in din[7:0]
// PORTS
//  clock      in   1   single clock, rising-edge
//  rst        in   1   asynchronous, active-low reset
//  en         in   1   input strobe; din, shift and direction are sampled when en=1
//  din        in   N   input character (ASCII)
//  shift      in   5   rotation amount 0..31, reduced modulo 26
//  direction  in   2   00 bypass, 01 encrypt (+shift), 10 decrypt (-shift), 11 bypass
//  dout       out  N   registered output character
//  v          out  1   dout valid, high for one cycle per accepted input
// BEHAVIOUR
//  - One clock; reset is asynchronous and active-low (rst=0 resets immediately).
//  - Reset: dout=0, v=0. No other state.
//  - Latency 1: on a rising edge with en=1, dout <= f(din, shift, direction) and v <= 1.
//  - On a rising edge with en=0: v <= 0 and dout holds its previous value.
//  - Back-to-back: en high on consecutive cycles gives one result per cycle. No stall
//    and no backpressure.
//  - Effective shift s = shift mod 26 (0..25): 26->0, 27->1 ... 31->5.
//  - Uppercase (0x41..0x5A):
//      encrypt: dout = 0x41 + ((din-0x41+s) mod 26)
//      decrypt: dout = 0x41 + ((din-0x41-s+26) mod 26)
//  - Lowercase (0x61..0x7A): same as uppercase with base 0x61; case is preserved.
//  - Every other byte (digits, control, punctuation, >=0x80) passes unchanged in all
//    modes.
//  - Bypass modes (00, 11): dout = din, and v still pulses.
//  - s=0 in any mode: dout = din.
//  - Compute with an internal 6-bit offset so that +s never overflows before the mod-26
//    correction. A single conditional subtract (encrypt) or add (decrypt) of 26 is
//    sufficient.
//  - Inputs may change on any cycle. Only values present at an en=1 edge matter, and no
//    input history is kept.
//  - Reset asserted mid-stream: dout and v clear at once. The first result after
//    release needs a new en=1 edge.
//  - Invariant: for any byte b and any shift, decrypt(encrypt(b)) == b.
// TESTING
//  1. rst=0 at t=0 with en=0 -> dout=0x00, v=0. Release; en=0 for 10 cycles -> v stays
//     0 and dout holds 0x00.
//  2. dir=01, shift=1, din=0x41 'A' -> next cycle dout=0x42, v=1. din=0x5A 'Z' -> 0x41.
//     din=0x7A 'z' -> 0x61.
//  3. dir=10, shift=5, din=0x41 -> 0x56 'V'. shift=26, din=0x6D -> 0x6D.
//     shift=31, din=0x62 'b' -> 0x77 'w'.
//  4. Non-letter: din=0x08, en=1, dir 00/01/10/11, shift 1,5,10,15,20,25,26 -> dout=0x08
//     every cycle, v=1 every cycle.
//  5. Streaming: en=1 for 52 cycles, din sweeps 'A'..'Z','a'..'z' with dir=01, shift=10.
//     Feed the outputs back with dir=10 -> originals recovered, v continuous.
//     Drop en for 1 cycle -> v=0 that cycle and dout held.
//  6. Assert rst mid-stream, asynchronously between edges -> dout=0 and v=0 before the
//     next edge. Release; the next en=1 input produces a correct result one cycle later.

Source files
------------

// File: rtl/encryption_core.sv
// Byte-serial Caesar rotation cipher: one character per enabled cycle, registered
// result with a single-cycle valid strobe. Letters rotate with wrap, case preserved.
module encryption_core #(
    parameter int N = 8
) (
    input  logic         clock,
    input  logic         rst,
    input  logic         en,
    input  logic [N-1:0] din,
    input  logic [4:0]   shift,
    input  logic [1:0]   direction,
    output logic [N-1:0] dout,
    output logic         v
);

    logic [7:0]   b;
    logic         is_upper;
    logic         is_lower;
    logic [4:0]   s;
    logic [5:0]   idx;
    logic [5:0]   off;
    logic [5:0]   sum;
    logic [N-1:0] result;

    assign b        = din[7:0];
    assign is_upper = (b >= 8'h41) && (b <= 8'h5A);
    assign is_lower = (b >= 8'h61) && (b <= 8'h7A);
    assign s        = (shift >= 5'd26) ? shift - 5'd26 : shift;

    // 'A' and 'a' both carry 5'd1 in their low bits, so one index path serves both cases
    // and the upper three bits keep the case untouched.
    assign idx = {1'b0, b[4:0] - 5'd1};

    always_comb begin
        off    = idx;
        sum    = '0;
        result = din;
        if (is_upper || is_lower) begin
            unique case (direction)
                2'b01: begin
                    sum = idx + {1'b0, s};
                    off = (sum >= 6'd26) ? sum - 6'd26 : sum;
                end
                2'b10: begin
                    off = (idx >= {1'b0, s}) ? idx - {1'b0, s}
                                             : idx + 6'd26 - {1'b0, s};
                end
                default: off = idx;
            endcase
            result[7:0] = {b[7:5], off[4:0] + 5'd1};
        end
    end

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            dout <= '0;
            v    <= 1'b0;
        end else begin
            v <= en;
            if (en) begin
                dout <= result;
            end
        end
    end

endmodule

// File: tb/tb_encryption_core.sv
// Self-checking bench for encryption_core: scoreboard queue of expected bytes filled
// as stimulus is driven and drained when the registered result appears.
module tb_encryption_core;

    logic       clock;
    logic       rst;
    logic       en;
    logic [7:0] din;
    logic [4:0] shift;
    logic [1:0] direction;
    logic [7:0] dout;
    logic       v;

    int unsigned tests = 0;
    int unsigned fails = 0;
    logic [7:0]  sb[$];

    encryption_core #(.N(8)) dut (
        .clock     (clock),
        .rst       (rst),
        .en        (en),
        .din       (din),
        .shift     (shift),
        .direction (direction),
        .dout      (dout),
        .v         (v)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [7:0] model(input logic [7:0] c, input int sh, input logic [1:0] dir);
        int s;
        int base;
        int k;
        s = sh % 26;
        if (c >= 8'h41 && c <= 8'h5A)      base = 65;
        else if (c >= 8'h61 && c <= 8'h7A) base = 97;
        else                               return c;
        k = int'(c) - base;
        if (dir == 2'b01)      k = (k + s) % 26;
        else if (dir == 2'b10) k = (k - s + 26) % 26;
        return 8'(base + k);
    endfunction

    task automatic drive(input logic [7:0] c, input logic [4:0] sh, input logic [1:0] dir);
        @(negedge clock);
        en        = 1'b1;
        din       = c;
        shift     = sh;
        direction = dir;
        sb.push_back(model(c, int'(sh), dir));
    endtask

    task automatic idle();
        @(negedge clock);
        en  = 1'b0;
        din = $urandom_range(255, 0);
    endtask

    task automatic test_reset();
        logic [7:0] exp;
        rst = 1'b0; en = 1'b0; din = 8'h55; shift = 5'd3; direction = 2'b01;
        #1;
        tests++;
        if (dout !== 8'h00 || v !== 1'b0) begin
            fails++;
            $display("FAIL reset_state: dout=%h v=%b expected dout=00 v=0", dout, v);
        end
        @(negedge clock);
        rst = 1'b1;
        exp = 8'h00;
        for (int i = 0; i < 10; i++) begin
            idle();
            @(posedge clock); #1;
            tests++;
            if (v !== 1'b0 || dout !== exp) begin
                fails++;
                $display("FAIL idle_after_reset[%0d]: dout=%h v=%b expected dout=%h v=0", i, dout, v, exp);
            end
        end
    endtask

    task automatic test_encrypt_decrypt();
        logic [7:0]  vin [7];
        logic [4:0]  vsh [7];
        logic [1:0]  vdir[7];
        logic [7:0]  exp;
        vin  = '{8'h41, 8'h5A, 8'h7A, 8'h41, 8'h6D, 8'h62, 8'h4D};
        vsh  = '{5'd1,  5'd1,  5'd1,  5'd5,  5'd26, 5'd31, 5'd0};
        vdir = '{2'b01, 2'b01, 2'b01, 2'b10, 2'b10, 2'b10, 2'b01};
        for (int i = 0; i < 7; i++) begin
            drive(vin[i], vsh[i], vdir[i]);
            @(posedge clock); #1;
            exp = sb.pop_front();
            tests++;
            if (v !== 1'b1 || dout !== exp) begin
                fails++;
                $display("FAIL rotate[%0d]: dout=%h v=%b expected dout=%h v=1", i, dout, v, exp);
            end
        end
        // Hand-derived anchors independent of the model.
        drive(8'h62, 5'd31, 2'b10);
        @(posedge clock); #1;
        void'(sb.pop_front());
        tests++;
        if (dout !== 8'h77) begin
            fails++;
            $display("FAIL decrypt_b_31: dout=%h expected 77", dout);
        end
        drive(8'h41, 5'd5, 2'b10);
        @(posedge clock); #1;
        void'(sb.pop_front());
        tests++;
        if (dout !== 8'h56) begin
            fails++;
            $display("FAIL decrypt_A_5: dout=%h expected 56", dout);
        end
        drive(8'h7A, 5'd27, 2'b01);
        @(posedge clock); #1;
        void'(sb.pop_front());
        tests++;
        if (dout !== 8'h61) begin
            fails++;
            $display("FAIL encrypt_z_27: dout=%h expected 61", dout);
        end
    endtask

    task automatic test_non_letter_and_bypass();
        logic [4:0] shs[7];
        logic [7:0] exp;
        logic [1:0] d;
        shs = '{5'd1, 5'd5, 5'd10, 5'd15, 5'd20, 5'd25, 5'd26};
        for (int di = 0; di < 4; di++) begin
            for (int j = 0; j < 7; j++) begin
                d = 2'(di);
                drive(8'h08, shs[j], d);
                @(posedge clock); #1;
                exp = sb.pop_front();
                tests++;
                if (v !== 1'b1 || dout !== exp || dout !== 8'h08) begin
                    fails++;
                    $display("FAIL non_letter[dir=%0d sh=%0d]: dout=%h v=%b expected dout=08 v=1", di, shs[j], dout, v);
                end
            end
        end
        for (int di = 0; di < 4; di += 3) begin
            d = 2'(di);
            drive(8'h51, 5'd7, d);
            @(posedge clock); #1;
            exp = sb.pop_front();
            tests++;
            if (v !== 1'b1 || dout !== exp || dout !== 8'h51) begin
                fails++;
                $display("FAIL bypass[dir=%0d]: dout=%h v=%b expected dout=51 v=1", di, dout, v);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] orig[52];
        logic [7:0] ciph[52];
        logic [7:0] exp;
        logic [7:0] held;
        for (int i = 0; i < 26; i++) begin
            orig[i]      = 8'(65 + i);
            orig[i + 26] = 8'(97 + i);
        end
        for (int i = 0; i < 52; i++) begin
            drive(orig[i], 5'd10, 2'b01);
            @(posedge clock); #1;
            exp = sb.pop_front();
            ciph[i] = dout;
            tests++;
            if (v !== 1'b1 || dout !== exp) begin
                fails++;
                $display("FAIL stream_enc[%0d]: dout=%h v=%b expected dout=%h v=1", i, dout, v, exp);
            end
        end
        for (int i = 0; i < 52; i++) begin
            drive(ciph[i], 5'd10, 2'b10);
            @(posedge clock); #1;
            void'(sb.pop_front());
            tests++;
            if (v !== 1'b1 || dout !== orig[i]) begin
                fails++;
                $display("FAIL stream_dec[%0d]: dout=%h v=%b expected dout=%h v=1", i, dout, v, orig[i]);
            end
        end
        held = dout;
        idle();
        @(posedge clock); #1;
        tests++;
        if (v !== 1'b0 || dout !== held) begin
            fails++;
            $display("FAIL en_gap: dout=%h v=%b expected dout=%h v=0", dout, v, held);
        end
    endtask

    task automatic test_midstream_reset();
        logic [7:0] exp;
        drive(8'h48, 5'd3, 2'b01);
        @(posedge clock); #1;
        void'(sb.pop_front());
        drive(8'h49, 5'd3, 2'b01);
        @(posedge clock); #2;
        en  = 1'b0;
        rst = 1'b0;
        #1;
        tests++;
        if (dout !== 8'h00 || v !== 1'b0) begin
            fails++;
            $display("FAIL async_reset: dout=%h v=%b expected dout=00 v=0", dout, v);
        end
        sb.delete();
        @(negedge clock);
        rst = 1'b1;
        @(posedge clock); #1;
        tests++;
        if (dout !== 8'h00 || v !== 1'b0) begin
            fails++;
            $display("FAIL post_release_idle: dout=%h v=%b expected dout=00 v=0", dout, v);
        end
        drive(8'h6B, 5'd29, 2'b10);
        @(posedge clock); #1;
        exp = sb.pop_front();
        tests++;
        if (v !== 1'b1 || dout !== exp || dout !== 8'h68) begin
            fails++;
            $display("FAIL after_release: dout=%h v=%b expected dout=%h v=1", dout, v, exp);
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_encrypt_decrypt();
        test_non_letter_and_bypass();
        test_back_to_back();
        test_midstream_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
